// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and sizing helpers for the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CKSUM_EN (see imem_loader.sv).
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_DATA_W = 32;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    // Byte counter runs 0..BYTES_PER_WORD-1; never narrower than one bit.
    function automatic int bcnt_width(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(DEF_DATA_W);
    localparam int BCNT_W         = bcnt_width(DEF_DATA_W);

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream valid/ready channel feeding the loader.
// master = byte source (e.g. UART receiver), slave = imem_loader.
interface imem_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: shifts bytes (MSB first) into a word and presents it
// left-justified, so a partial final word has zero-filled low bytes.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int NB = BYTES_PER_WORD,
    parameter int CW = BCNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic [7:0]        byte_i,
    output logic [NB*8-1:0]   word_o,
    output logic              full_o
);

    localparam int DW = NB * 8;

    logic [DW-1:0] data_q;
    logic [CW-1:0] cnt_q;

    // Shift register and byte counter; counter wraps to 0 after a full word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (shift_i) begin
            data_q <= (data_q << 8) | DW'(byte_i);
            cnt_q  <= (cnt_q == CW'(NB - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    // A zero count here means a complete word (a write only follows an accepted byte).
    always_comb begin
        full_o = shift_i && (cnt_q == CW'(NB - 1));
        if (cnt_q == '0) begin
            word_o = data_q;
        end else begin
            word_o = data_q << (8 * (NB - int'(cnt_q)));
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a boot byte stream into words and writes them into the
// instruction RAM from word 0, holding the CPU in reset until the image is in.
// Optional feature: define IMEM_LOADER_CKSUM_EN to add the cksum output
// (running XOR of all accepted bytes, cleared on start).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int WORDS  = 64,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      s_in,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W:0]   word_count
`ifdef IMEM_LOADER_CKSUM_EN
    ,
    output logic [7:0]        cksum
`endif
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [ADDR_W:0]     wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   wd_q;
    logic                last_q;
    logic                accept;
    logic                clr;
    logic [DATA_W-1:0]   pk_word;
    logic                pk_full;

    imem_loader_byte_packer #(
        .NB (bytes_per_word(DATA_W)),
        .CW (bcnt_width(DATA_W))
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clr),
        .shift_i (accept),
        .byte_i  (s_in.in_data),
        .word_o  (pk_word),
        .full_o  (pk_full)
    );

    // Next-state, address/count updates and handshake outputs.
    always_comb begin
        state_d = state_q;
        wa_d    = wa_q;
        wcnt_d  = wcnt_q;
        clr     = 1'b0;
        s_in.in_ready = (state_q == ST_LOAD);
        accept  = s_in.in_valid && (state_q == ST_LOAD);
        we      = (state_q == ST_WRITE);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    wa_d    = '0;
                    wcnt_d  = '0;
                    clr     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept && (pk_full || s_in.in_last)) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wcnt_d = wcnt_q + 1'b1;
                if (last_q || (wa_q == ADDR_W'(WORDS - 1))) begin
                    state_d = ST_DONE;
                end else begin
                    wa_d    = wa_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and write-port registers; reset aborts any load in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            wa_q    <= '0;
            wcnt_q  <= '0;
            wd_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wa_q    <= wa_d;
            wcnt_q  <= wcnt_d;
            if (state_q == ST_WRITE) begin
                wd_q <= pk_word;
            end
            if (clr) begin
                last_q <= 1'b0;
            end else if (accept) begin
                last_q <= s_in.in_last;
            end
        end
    end

    // wd shows the packed word during the write and holds it afterwards.
    assign wd         = (state_q == ST_WRITE) ? pk_word : wd_q;
    assign wa         = wa_q;
    assign word_count = wcnt_q;
    assign done       = (state_q == ST_DONE);
    assign cpu_hold   = (state_q != ST_DONE);

`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0] cksum_q;

    // Running XOR of accepted bytes, restarted with each load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cksum_q <= '0;
        end else if (clr) begin
            cksum_q <= '0;
        end else if (accept) begin
            cksum_q <= cksum_q ^ s_in.in_data;
        end
    end

    assign cksum = cksum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Inputs are driven 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic        cpu_hold;
    logic        done;
    logic [6:0]  word_count;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]  cksum;
`endif

    imem_loader_if s_if ();

    imem_loader #(
        .ADDR_W (6),
        .WORDS  (64),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_in       (s_if),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .word_count (word_count)
`ifdef IMEM_LOADER_CKSUM_EN
        ,
        .cksum      (cksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  stim_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          n_wr  = 0;

    // reference packer state
    logic [31:0] m_acc;
    int          m_cnt;
    int          m_addr;
    logic [7:0]  m_ck;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_start();
        m_acc  = '0;
        m_cnt  = 0;
        m_addr = 0;
        m_ck   = '0;
    endtask

    task automatic model_accept(input logic [7:0] b, input logic last);
        m_acc = {m_acc[23:0], b};
        m_cnt++;
        m_ck  = m_ck ^ b;
        if (m_cnt == 4 || last) begin
            sb_q.push_back({6'(m_addr), m_acc << (8 * (4 - m_cnt))});
            m_acc = '0;
            m_cnt = 0;
            m_addr++;
        end
    endtask

    // Monitor: count handshakes and compare every write against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (s_if.in_valid && s_if.in_ready) n_acc++;
        if (we) begin
            n_wr++;
            check_val("wr_ready_low", 64'(s_if.in_ready), 64'd0);
            if (sb_q.size() == 0) begin
                check_val("wr_expected", 64'(sb_q.size()), 64'd1);
            end else begin
                e = sb_q.pop_front();
                check_val("wr_addr", 64'(wa), 64'(e.a));
                check_val("wr_data", 64'(wd), 64'(e.d));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_start();
    endtask

    // Offer stim_q with in_valid held high; in_last optionally on the final byte.
    task automatic send_stream(input bit last_at_end, input string tag);
        int i = 0;
        int guard = 0;
        int n = stim_q.size();
        while (i < n && guard < 2000) begin
            s_if.in_valid = 1'b1;
            s_if.in_data  = stim_q[i];
            s_if.in_last  = last_at_end && (i == n - 1);
            if (s_if.in_ready) begin
                model_accept(stim_q[i], s_if.in_last);
                i++;
            end
            step();
            guard++;
        end
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
        s_if.in_data  = '0;
        if (i < n) check_val({tag, "_stalled"}, 64'(i), 64'(n));
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_done"}, 64'(done), 64'd1);
        step();
    endtask

    initial begin
        int acc0;
        int wr0;
        reset         = 1'b0;
        start         = 1'b0;
        s_if.in_valid = 1'b0;
        s_if.in_data  = '0;
        s_if.in_last  = 1'b0;
        model_start();

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_ready", 64'(s_if.in_ready), 64'd0);
        check_val("rst_we",    64'(we),            64'd0);
        check_val("rst_wa",    64'(wa),            64'd0);
        check_val("rst_wd",    64'(wd),            64'd0);
        check_val("rst_done",  64'(done),          64'd0);
        check_val("rst_wcnt",  64'(word_count),    64'd0);
        check_val("rst_hold",  64'(cpu_hold),      64'd1);
        step();
        reset = 1'b1;
        step();

        // single full word with in_last
        pulse_start();
        check_val("t1_hold", 64'(cpu_hold), 64'd1);
        check_val("t1_ready", 64'(s_if.in_ready), 64'd1);
        stim_q = '{8'h20, 8'h08, 8'h00, 8'h05};
        send_stream(1'b1, "t1");
        wait_done("t1");
        check_val("t1_hold_rel", 64'(cpu_hold), 64'd0);
        check_val("t1_wcnt", 64'(word_count), 64'd1);
        check_val("t1_nwr", 64'(n_wr), 64'd1);
`ifdef IMEM_LOADER_CKSUM_EN
        check_val("t1_cksum", 64'(cksum), 64'(m_ck));
`endif

        // three words back-to-back
        acc0 = n_acc;
        wr0  = n_wr;
        pulse_start();
        check_val("t2_hold_reload", 64'(cpu_hold), 64'd1);
        check_val("t2_done_clr", 64'(done), 64'd0);
        stim_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67,
                   8'h89, 8'hAB, 8'hCD, 8'hEF};
        send_stream(1'b1, "t2");
        wait_done("t2");
        check_val("t2_bytes", 64'(n_acc - acc0), 64'd12);
        check_val("t2_writes", 64'(n_wr - wr0), 64'd3);
        check_val("t2_wcnt", 64'(word_count), 64'd3);
        check_val("t2_wa", 64'(wa), 64'd2);

        // partial word
        wr0 = n_wr;
        pulse_start();
        stim_q = '{8'hAC, 8'h10};
        send_stream(1'b1, "t3");
        wait_done("t3");
        check_val("t3_writes", 64'(n_wr - wr0), 64'd1);
        check_val("t3_wd_hold", 64'(wd), 64'hAC100000);
        check_val("t3_wcnt", 64'(word_count), 64'd1);

        // full RAM without in_last, then overflow byte
        acc0 = n_acc;
        wr0  = n_wr;
        pulse_start();
        stim_q.delete();
        for (int i = 0; i < 256; i++) stim_q.push_back(8'((i * 7 + 3) & 8'hFF));
        send_stream(1'b0, "t4");
        wait_done("t4");
        check_val("t4_writes", 64'(n_wr - wr0), 64'd64);
        check_val("t4_wa", 64'(wa), 64'd63);
        check_val("t4_wcnt", 64'(word_count), 64'd64);
        s_if.in_valid = 1'b1;
        s_if.in_data  = 8'h5A;
        repeat (8) step();
        check_val("t4_ovf_ready", 64'(s_if.in_ready), 64'd0);
        s_if.in_valid = 1'b0;
        check_val("t4_ovf_bytes", 64'(n_acc - acc0), 64'd256);

        // reset in the middle of word 5
        pulse_start();
        stim_q.delete();
        for (int i = 0; i < 22; i++) stim_q.push_back(8'(8'h40 + i));
        send_stream(1'b0, "t5");
        reset = 1'b0;
        m_acc = '0;
        m_cnt = 0;
        #1;
        wr0 = n_wr;
        check_val("t5_we",    64'(we),         64'd0);
        check_val("t5_wa",    64'(wa),         64'd0);
        check_val("t5_wd",    64'(wd),         64'd0);
        check_val("t5_wcnt",  64'(word_count), 64'd0);
        check_val("t5_hold",  64'(cpu_hold),   64'd1);
        check_val("t5_ready", 64'(s_if.in_ready), 64'd0);
        repeat (3) step();
        check_val("t5_no_wr", 64'(n_wr - wr0), 64'd0);
        reset = 1'b1;
        step();
        pulse_start();
        stim_q = '{8'h13, 8'h57, 8'h9B, 8'hDF};
        send_stream(1'b1, "t5r");
        wait_done("t5r");
        check_val("t5r_wa", 64'(wa), 64'd0);
        check_val("t5r_wcnt", 64'(word_count), 64'd1);

`ifdef IMEM_LOADER_CKSUM_EN
        // checksum
        pulse_start();
        stim_q = '{8'h01, 8'h02, 8'h04, 8'h08};
        send_stream(1'b1, "t6");
        wait_done("t6");
        check_val("t6_cksum", 64'(cksum), 64'h0F);
        pulse_start();
        check_val("t6_cksum_clr", 64'(cksum), 64'h00);
        stim_q = '{8'h11};
        send_stream(1'b1, "t6b");
        wait_done("t6b");
`endif

        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
